// File: rtl/cond_eval.sv
// cond_eval: resolves a conditional branch against the processor flags word and
// holds the result in a one-entry valid/ready output register (EMPTY/FULL).
// Optional statistics counters are built only when COND_EVAL_BRANCH_STATS_EN is
// defined; otherwise branch_count and taken_count are tied to zero.
module cond_eval #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] flags,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc,
  output logic [15:0]      branch_count,
  output logic [15:0]      taken_count
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic             taken_q;
  logic [WIDTH-1:0] next_pc_q;
  logic             cond_true;
  logic             accept;

  // Flag bit positions within the status word.
  logic flag_c, flag_l, flag_f, flag_z, flag_n;
  assign flag_c = flags[0];
  assign flag_l = flags[2];
  assign flag_f = flags[5];
  assign flag_z = flags[6];
  assign flag_n = flags[7];

  // Remaining status bits play no part in condition evaluation.
  logic unused_flags;
  assign unused_flags = ^{flags[WIDTH-1:8], flags[4:3], flags[1]};

  // Condition-code decode against the live flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'd0:  cond_true = flag_z;
      4'd1:  cond_true = ~flag_z;
      4'd2:  cond_true = flag_c;
      4'd3:  cond_true = ~flag_c;
      4'd4:  cond_true = flag_l;
      4'd5:  cond_true = ~flag_l;
      4'd6:  cond_true = flag_n;
      4'd7:  cond_true = ~flag_n;
      4'd8:  cond_true = flag_f;
      4'd9:  cond_true = ~flag_f;
      4'd10: cond_true = ~flag_l & ~flag_z;
      4'd11: cond_true = flag_l | flag_z;
      4'd12: cond_true = ~flag_n & ~flag_z;
      4'd13: cond_true = flag_n | flag_z;
      4'd14: cond_true = 1'b1;
      4'd15: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Handshake and next-state: flush wins over resp_ready and blocks acceptance.
  always_comb begin
    state_d   = state_q;
    req_ready = ((state_q == StEmpty) | resp_ready) & ~flush;
    accept    = req_valid & req_ready;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if ((state_q == StFull) && resp_ready) begin
      state_d = StEmpty;
    end
  end

  // State and response registers; the response is captured only on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        taken_q   <= cond_true;
        next_pc_q <= cond_true ? target : pc_next;
      end
    end
  end

  assign resp_valid = (state_q == StFull);
  assign taken      = taken_q;
  assign next_pc    = next_pc_q;

`ifdef COND_EVAL_BRANCH_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] taken_cnt_q;

  // Saturating counters of accepted and taken branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (accept) begin
      if (branch_cnt_q != 16'hFFFF) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
      end
      if (cond_true && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_q <= taken_cnt_q + 16'd1;
      end
    end
  end

  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;
`else
  assign branch_count = 16'd0;
  assign taken_count  = 16'd0;
`endif

endmodule

// File: tb/tb_cond_eval.sv
// Directed testbench for cond_eval: reset, basic resolve, full cond sweep,
// stall/back-to-back, flush, reset while full, and statistics counters.
module tb_cond_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] flags;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  cond;
  logic [15:0] target;
  logic [15:0] pc_next;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic        taken;
  logic [15:0] next_pc;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  int n_checks = 0;
  int n_pass   = 0;

  cond_eval #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .flags        (flags),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .cond         (cond),
    .target       (target),
    .pc_next      (pc_next),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .taken        (taken),
    .next_pc      (next_pc),
    .branch_count (branch_count),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flags = 16'h00FF; req_valid = 1'b1; cond = 4'd14;
    target = 16'hAAAA; pc_next = 16'h5555; flush = 1'b0; resp_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (taken !== 1'b0) $display("FAIL reset_taken: got %b want 0", taken); else n_pass++;
    n_checks++; if (next_pc !== 16'h0000) $display("FAIL reset_next_pc: got %h want 0000", next_pc); else n_pass++;
    n_checks++; if (branch_count !== 16'h0000) $display("FAIL reset_branch_count: got %h want 0000", branch_count); else n_pass++;
    n_checks++; if (taken_count !== 16'h0000) $display("FAIL reset_taken_count: got %h want 0000", taken_count); else n_pass++;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_basic();
    flags = 16'h0040; cond = 4'd0; target = 16'h0100; pc_next = 16'h0011;
    req_valid = 1'b1; resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL basic_req_ready: got %b want 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", resp_valid); else n_pass++;
    n_checks++; if (taken !== 1'b1) $display("FAIL basic_taken: got %b want 1", taken); else n_pass++;
    n_checks++; if (next_pc !== 16'h0100) $display("FAIL basic_next_pc: got %h want 0100", next_pc); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", resp_valid); else n_pass++;
  endtask

  // Expected taken bit per cond code (bit index = cond) for each flags value.
  task automatic test_cond_sweep();
    logic [15:0] fl [5];
    logic [15:0] mask [5];
    logic        exp_t;
    logic [15:0] exp_pc;
    fl[0] = 16'h0000; mask[0] = 16'h56AA;
    fl[1] = 16'h0004; mask[1] = 16'h5A9A;
    fl[2] = 16'h0044; mask[2] = 16'h6A99;
    fl[3] = 16'h0080; mask[3] = 16'h666A;
    fl[4] = 16'h00A5; mask[4] = 16'h6956;
    resp_ready = 1'b1;
    for (int fi = 0; fi < 5; fi++) begin
      for (int c = 0; c < 16; c++) begin
        flags = fl[fi]; cond = 4'(c);
        target  = 16'h1000 | 16'(fi << 8) | 16'(c);
        pc_next = 16'h2000 | 16'(fi << 8) | 16'(c);
        req_valid = 1'b1;
        tick();
        exp_t  = mask[fi][c];
        exp_pc = exp_t ? (16'h1000 | 16'(fi << 8) | 16'(c)) : (16'h2000 | 16'(fi << 8) | 16'(c));
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL sweep_valid f=%h c=%0d: got %b want 1", fl[fi], c, resp_valid); else n_pass++;
        n_checks++; if (taken !== exp_t) $display("FAIL sweep_taken f=%h c=%0d: got %b want %b", fl[fi], c, taken, exp_t); else n_pass++;
        n_checks++; if (next_pc !== exp_pc) $display("FAIL sweep_next_pc f=%h c=%0d: got %h want %h", fl[fi], c, next_pc, exp_pc); else n_pass++;
      end
    end
    req_valid = 1'b0;
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL sweep_drain: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_stall_back_to_back();
    resp_ready = 1'b0;
    flags = 16'h0040; cond = 4'd0; target = 16'h0300; pc_next = 16'h0311; req_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      flags = (i % 2 == 0) ? 16'h0000 : 16'h00FF;
      cond = 4'd15; target = 16'h0E00; pc_next = 16'h0E11;
      #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); else n_pass++;
      tick();
      n_checks++; if (resp_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, resp_valid); else n_pass++;
      n_checks++; if (taken !== 1'b1) $display("FAIL stall_taken[%0d]: got %b want 1", i, taken); else n_pass++;
      n_checks++; if (next_pc !== 16'h0300) $display("FAIL stall_next_pc[%0d]: got %h want 0300", i, next_pc); else n_pass++;
    end
    resp_ready = 1'b1;
    cond = 4'd14; target = 16'h0400; pc_next = 16'h0401;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready: got %b want 1", req_ready); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 16'h0400)
      $display("FAIL b2b_resp0: got v=%b t=%b pc=%h want v=1 t=1 pc=0400", resp_valid, taken, next_pc);
    else n_pass++;
    cond = 4'd15; target = 16'h0500; pc_next = 16'h0511;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || taken !== 1'b0 || next_pc !== 16'h0511)
      $display("FAIL b2b_resp1: got v=%b t=%b pc=%h want v=1 t=0 pc=0511", resp_valid, taken, next_pc);
    else n_pass++;
    flags = 16'h0000; cond = 4'd1; target = 16'h0600; pc_next = 16'h0611;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 16'h0600)
      $display("FAIL b2b_resp2: got v=%b t=%b pc=%h want v=1 t=1 pc=0600", resp_valid, taken, next_pc);
    else n_pass++;
    req_valid = 1'b0;
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_flush();
    resp_ready = 1'b0;
    flags = 16'h0000; cond = 4'd15; target = 16'h0A00; pc_next = 16'h0A11; req_valid = 1'b1;
    tick();
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL flush_setup: got %b want 1", resp_valid); else n_pass++;
    flush = 1'b1; resp_ready = 1'b1; cond = 4'd14; target = 16'h0700; pc_next = 16'h0711;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b want 0", req_ready); else n_pass++;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (next_pc !== 16'h0A11) $display("FAIL flush_not_loaded: got %h want 0a11", next_pc); else n_pass++;
    tick();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL flush_stays_empty: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_reset_full();
    resp_ready = 1'b0;
    flags = 16'h0001; cond = 4'd2; target = 16'h0B00; pc_next = 16'h0B11; req_valid = 1'b1;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || next_pc !== 16'h0B00)
      $display("FAIL rstfull_setup: got v=%b pc=%h want v=1 pc=0b00", resp_valid, next_pc);
    else n_pass++;
    reset = 1'b1; flush = 1'b1; resp_ready = 1'b1; cond = 4'd14;
    tick();
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rstfull_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (taken !== 1'b0) $display("FAIL rstfull_taken: got %b want 0", taken); else n_pass++;
    n_checks++; if (next_pc !== 16'h0000) $display("FAIL rstfull_next_pc: got %h want 0000", next_pc); else n_pass++;
    n_checks++; if (branch_count !== 16'h0000 || taken_count !== 16'h0000)
      $display("FAIL rstfull_counters: got %h/%h want 0000/0000", branch_count, taken_count);
    else n_pass++;
  endtask

  task automatic test_counters();
    logic [15:0] exp_b, exp_t, exp_bs, exp_ts;
`ifdef COND_EVAL_BRANCH_STATS_EN
    exp_b = 16'd5; exp_t = 16'd3; exp_bs = 16'hFFFF; exp_ts = 16'hFFFF;
`else
    exp_b = 16'd0; exp_t = 16'd0; exp_bs = 16'd0; exp_ts = 16'd0;
`endif
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    tick();
    reset = 1'b0;
    flags = 16'h0000; target = 16'h0C00; pc_next = 16'h0C11; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cond = (i % 2 == 0) ? 4'd14 : 4'd15;
      tick();
    end
    req_valid = 1'b0;
    tick();
    n_checks++; if (branch_count !== exp_b) $display("FAIL cnt_branch5: got %h want %h", branch_count, exp_b); else n_pass++;
    n_checks++; if (taken_count !== exp_t) $display("FAIL cnt_taken3: got %h want %h", taken_count, exp_t); else n_pass++;
    cond = 4'd14; req_valid = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (branch_count !== exp_bs) $display("FAIL cnt_branch_sat: got %h want %h", branch_count, exp_bs); else n_pass++;
    n_checks++; if (taken_count !== exp_ts) $display("FAIL cnt_taken_sat: got %h want %h", taken_count, exp_ts); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cond_sweep();
    test_stall_back_to_back();
    test_flush();
    test_reset_full();
    test_counters();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
